// File: rtl/switch_conditioner.sv
// Conditions 16 raw slide switches: two-flop synchronizer, tick-paced debounce,
// and single-cycle rise/fall pulses for the downstream game logic.
module switch_conditioner #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switch,
  output logic [15:0] sw_stable,
  output logic [15:0] sw_rise,
  output logic [15:0] sw_fall,
  output logic        sw_any_edge
);

  localparam int unsigned NBITS = 16;
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW    = 4;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

  logic [NBITS-1:0] sync1;
  logic [NBITS-1:0] sync2;
  logic [PW-1:0]    pcnt;
  logic             tick_c;
  logic [CW-1:0]    cnt      [NBITS];
  logic [CW-1:0]    cnt_next [NBITS];
  logic [NBITS-1:0] stable_next;
  logic [NBITS-1:0] rise_next;
  logic [NBITS-1:0] fall_next;

  // Two-flop synchronizer, nothing between the stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

  // Shared sample-tick prescaler; TICK_DIV of 1 keeps the tick high
  assign tick_c = (pcnt == PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick_c) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Per-bit disagreement counters; any agreeing tick restarts the count
  always_comb begin
    stable_next = sw_stable;
    rise_next   = '0;
    fall_next   = '0;
    for (int i = 0; i < NBITS; i++) begin
      cnt_next[i] = cnt[i];
      if (tick_c) begin
        if (sync2[i] == sw_stable[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] >= CMAX) begin
          cnt_next[i]    = '0;
          stable_next[i] = sync2[i];
          rise_next[i]   = sync2[i];
          fall_next[i]   = ~sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= '0;
      end
      sw_stable   <= '0;
      sw_rise     <= '0;
      sw_fall     <= '0;
      sw_any_edge <= 1'b0;
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= cnt_next[i];
      end
      sw_stable   <= stable_next;
      sw_rise     <= rise_next;
      sw_fall     <= fall_next;
      sw_any_edge <= |(rise_next | fall_next);
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner: directed scenarios plus random
// switch activity against a sample-history reference model.
module tb_switch_conditioner;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        clk;
  logic        rst;
  logic [15:0] switch;
  logic [15:0] sw_stable;
  logic [15:0] sw_rise;
  logic [15:0] sw_fall;
  logic        sw_any_edge;

  int tests_run = 0;
  int failures  = 0;
  logic chk_en = 1'b0;

  switch_conditioner #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk),
    .rst(rst),
    .switch(switch),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_any_edge(sw_any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stable value flips on a tick once the last ST
  // tick-sampled synchronized values all disagree with it.
  logic [15:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_upd;
  logic        m_any;
  logic [15:0] m_hist [ST-1];
  int          m_n;

  always_comb begin
    m_upd = m_s2 ^ m_stable;
    for (int k = 0; k < ST - 1; k++) m_upd = m_upd & (m_hist[k] ^ m_stable);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_stable <= '0;
      m_rise <= '0; m_fall <= '0; m_any <= 1'b0; m_n <= 0;
      for (int k = 0; k < ST - 1; k++) m_hist[k] <= '0;
    end else begin
      m_s1 <= switch;
      m_s2 <= m_s1;
      m_n  <= m_n + 1;
      if ((m_n % TD) == TD - 1) begin
        m_hist[0] <= m_s2;
        for (int k = 1; k < ST - 1; k++) m_hist[k] <= m_hist[k-1];
        m_stable <= m_stable ^ m_upd;
        m_rise   <= m_upd & ~m_stable;
        m_fall   <= m_upd & m_stable;
        m_any    <= |m_upd;
      end else begin
        m_rise <= '0; m_fall <= '0; m_any <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests_run++;
      if (sw_stable !== m_stable || sw_rise !== m_rise || sw_fall !== m_fall || sw_any_edge !== m_any) begin
        failures++;
        $display("FAIL model_cmp t=%0t stable=%h exp %h rise=%h exp %h fall=%h exp %h any=%b exp %b",
                 $time, sw_stable, m_stable, sw_rise, m_rise, sw_fall, m_fall, sw_any_edge, m_any);
      end
    end
  end

  task automatic test_reset();
    int first, nr, na;
    logic [15:0] rv;
    rst = 1'b0; switch = 16'hFFFF;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({sw_stable, sw_rise, sw_fall, sw_any_edge} !== 49'd0) begin
      failures++;
      $display("FAIL reset_async stable=%h rise=%h fall=%h any=%b exp all 0", sw_stable, sw_rise, sw_fall, sw_any_edge);
    end
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first = 0; nr = 0; na = 0; rv = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (first == 0 && sw_stable === 16'hFFFF) first = i;
      if (sw_rise !== 16'h0000) begin nr++; rv = sw_rise; end
      if (sw_any_edge === 1'b1) na++;
    end
    tests_run++;
    if (first == 0 || first > 14) begin
      failures++;
      $display("FAIL reset_latency got cycle %0d exp 1..14", first);
    end
    tests_run++;
    if (nr != 1 || rv !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_rise pulses=%0d value=%h exp 1 pulse of ffff", nr, rv);
    end
    tests_run++;
    if (na != 1) begin
      failures++;
      $display("FAIL reset_any_edge cycles=%0d exp 1", na);
    end
    switch = 16'h0000;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_clean_toggle();
    int first, np;
    logic [15:0] other;
    for (int dir = 1; dir >= 0; dir--) begin
      switch[3] = 1'(dir);
      first = 0; np = 0; other = '0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (first == 0 && sw_stable[3] === 1'(dir)) first = i;
        if ((dir == 1 ? sw_rise[3] : sw_fall[3]) === 1'b1) np++;
        other = other | (sw_rise & ~16'h0008) | (sw_fall & ~16'h0008)
                      | (dir == 1 ? sw_fall & 16'h0008 : sw_rise & 16'h0008);
      end
      tests_run++;
      if (first < 11 || first > 14) begin
        failures++;
        $display("FAIL toggle_latency dir=%0d got %0d exp 11..14", dir, first);
      end
      tests_run++;
      if (np != 1 || other !== 16'h0000) begin
        failures++;
        $display("FAIL toggle_pulse dir=%0d pulses=%0d stray=%h exp 1 and 0000", dir, np, other);
      end
    end
  endtask

  task automatic test_glitch();
    int nr, nf;
    logic st;
    nr = 0; st = 1'b0;
    switch[7] = 1'b1;
    for (int i = 0; i < 31; i++) begin
      if (i == 6) switch[7] = 1'b0;
      @(negedge clk);
      if (sw_rise[7] === 1'b1) nr++;
      st = st | sw_stable[7];
    end
    tests_run++;
    if (nr != 0 || st !== 1'b0) begin
      failures++;
      $display("FAIL glitch_high rises=%0d stable_seen=%b exp 0 and 0", nr, st);
    end
    switch[9] = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (sw_stable[9] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_setup stable9=%b exp 1", sw_stable[9]);
    end
    nf = 0; st = 1'b1;
    switch[9] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      switch[9] = 1'b1;
      if (sw_fall[9] === 1'b1) nf++;
      st = st & sw_stable[9];
    end
    tests_run++;
    if (nf != 0 || st !== 1'b1) begin
      failures++;
      $display("FAIL glitch_low falls=%0d stable_held=%b exp 0 and 1", nf, st);
    end
    switch[9] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_bounce();
    int nr, at;
    nr = 0; at = 0;
    for (int c = 0; c < 70; c++) begin
      if (c < 40 && c % 3 == 0) switch[0] = ~switch[0];
      if (c == 40) switch[0] = 1'b1;
      @(negedge clk);
      if (sw_rise[0] === 1'b1) begin nr++; at = c; end
    end
    tests_run++;
    if (nr != 1 || at < 40) begin
      failures++;
      $display("FAIL bounce rises=%0d at cycle %0d exp 1 at >=40", nr, at);
    end
    tests_run++;
    if (sw_stable[0] !== 1'b1) begin
      failures++;
      $display("FAIL bounce_final stable0=%b exp 1", sw_stable[0]);
    end
    switch = 16'h0000;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_multi();
    int nr;
    logic [15:0] rv, fv;
    nr = 0; rv = '0; fv = '0;
    switch = 16'hA5A5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sw_rise !== 16'h0000) begin nr++; rv = sw_rise; end
      fv = fv | sw_fall;
    end
    tests_run++;
    if (nr != 1 || rv !== 16'hA5A5 || fv !== 16'h0000) begin
      failures++;
      $display("FAIL multi cycles=%0d rise=%h fall=%h exp 1 a5a5 0000", nr, rv, fv);
    end
  endtask

  task automatic test_mid_reset();
    int first, nr5, npre;
    switch = 16'hA585;
    repeat (20) @(negedge clk);
    tests_run++;
    if (sw_stable !== 16'hA585) begin
      failures++;
      $display("FAIL midrst_setup stable=%h exp a585", sw_stable);
    end
    switch = 16'hA5A5;
    npre = 0;
    repeat (8) begin
      @(negedge clk);
      if (sw_rise !== 16'h0000 || sw_fall !== 16'h0000) npre++;
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (npre != 0 || {sw_stable, sw_rise, sw_fall, sw_any_edge} !== 49'd0) begin
      failures++;
      $display("FAIL midrst_async pre_pulses=%0d stable=%h any=%b exp 0 0000 0", npre, sw_stable, sw_any_edge);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first = 0; nr5 = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (first == 0 && sw_stable[5] === 1'b1) first = i;
      if (sw_rise[5] === 1'b1) nr5++;
    end
    tests_run++;
    if (first < 11 || first > 14 || nr5 != 1) begin
      failures++;
      $display("FAIL midrst_rise latency=%0d rises=%0d exp 11..14 and 1", first, nr5);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 1) switch = 16'($urandom);
      else if (r < 6) switch = switch ^ (16'h0001 << $urandom_range(0, 15));
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_toggle();
    test_glitch();
    test_bounce();
    test_multi();
    test_mid_reset();
    test_random();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
